// File: rtl/lbus_blk_ctrl_pkg.sv
// Shared address map, CTRL bit positions and FSM state type for the local-bus
// control stage that sits in front of the block cipher core.
package lbus_blk_pkg;

  localparam logic [15:0] ADDR_CTRL = 16'h0002;
  localparam logic [15:0] ADDR_VER  = 16'h0004;
  localparam logic [15:0] ADDR_MODE = 16'h000C;
  localparam logic [15:0] ADDR_KEY  = 16'h0100;
  localparam logic [15:0] ADDR_DIN  = 16'h0140;
  localparam logic [15:0] ADDR_DOUT = 16'h0180;

  localparam int KEY_WORDS  = 8;
  localparam int DOUT_WORDS = 8;

  localparam int CTRL_START_D  = 0;
  localparam int CTRL_LOAD_K   = 1;
  localparam int CTRL_CORE_RST = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_KEY_BUSY  = 2'd1,
    ST_DATA_BUSY = 2'd2
  } blk_state_e;

  function automatic logic [15:0] word_addr(input logic [15:0] base, input int idx);
    return base + 16'(idx);
  endfunction

endpackage

// File: rtl/lbus_blk_ctrl_if.sv
// Host local bus: 16-bit address/data with active-low read and write strobes.
interface lbus_blk_ctrl_if;
  logic [15:0] lbus_a;
  logic [15:0] lbus_di;
  logic [15:0] lbus_do;
  logic        lbus_wrn;
  logic        lbus_rdn;

  modport master (output lbus_a, lbus_di, lbus_wrn, lbus_rdn, input lbus_do);
  modport slave  (input lbus_a, lbus_di, lbus_wrn, lbus_rdn, output lbus_do);
endinterface

// File: rtl/lbus_blk_ctrl_strobe_edge.sv
// Registers the bus strobes and turns them into single-cycle commit/sample pulses.
module lbus_strobe_edge (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrn,
  input  logic        rdn,
  input  logic [15:0] di,
  output logic        wr_commit,
  output logic        rd_sample,
  output logic [15:0] wr_data
);

  logic wrn_p0;
  logic rdn_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrn_p0 <= 1'b1;
      rdn_p0 <= 1'b1;
    end else begin
      wrn_p0 <= wrn;
      rdn_p0 <= rdn;
    end
  end

  // Write data is the last value seen while the strobe was low.
  always_ff @(posedge clk) begin
    if (!wrn) wr_data <= di;
  end

  assign wr_commit = !wrn_p0 && wrn;
  assign rd_sample = rdn_p0 && !rdn;

endmodule

// File: rtl/lbus_blk_ctrl.sv
// Local-bus register file and start/busy control for the block cipher core:
// key/data/mode registers, krdy/drdy pulses, busy tracking, watchdog, result capture.
module lbus_blk_ctrl
  import lbus_blk_pkg::*;
#(
  parameter int          DIN_W   = 496,
  parameter int          TMO_CYC = 65535,
  parameter logic [15:0] IP_VER  = 16'h0100
) (
  input  logic               clk,
  input  logic               rst,
  lbus_blk_ctrl_if.slave     lbus,
  output logic [127:0]       blk_kin,
  output logic [DIN_W-1:0]   blk_din,
  input  logic [127:0]       blk_dout,
  output logic               blk_krdy,
  output logic               blk_drdy,
  input  logic               blk_kvld,
  input  logic               blk_dvld,
  output logic               blk_encdec,
  output logic               blk_en,
  output logic               blk_rstn
);

  localparam int DIN_WORDS = DIN_W / 16;
  localparam int WDT_W     = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  logic             wr_commit;
  logic             rd_sample;
  logic [15:0]      wr_data;
  blk_state_e       state;
  logic             err;
  logic             core_rst;
  logic [WDT_W-1:0] wdt;
  logic [WDT_W-1:0] wdt_inc;
  logic             wdt_hit;
  logic [127:0]     dout_reg;
  logic [15:0]      rd_word;
  logic [15:0]      do_q;
  logic             ctrl_wr;
  logic             start_k;
  logic             start_d;

  lbus_strobe_edge u_strobe (
    .clk       (clk),
    .rst       (rst),
    .wrn       (lbus.lbus_wrn),
    .rdn       (lbus.lbus_rdn),
    .di        (lbus.lbus_di),
    .wr_commit (wr_commit),
    .rd_sample (rd_sample),
    .wr_data   (wr_data)
  );

  assign ctrl_wr = wr_commit && (lbus.lbus_a == ADDR_CTRL);

  // A core-reset write masks its own start bits; key load wins over data start;
  // a result arriving in the commit cycle suppresses a data start.
  assign start_k = ctrl_wr && !wr_data[CTRL_CORE_RST] && wr_data[CTRL_LOAD_K] &&
                   (state == ST_IDLE);
  assign start_d = ctrl_wr && !wr_data[CTRL_CORE_RST] && !wr_data[CTRL_LOAD_K] &&
                   wr_data[CTRL_START_D] && (state == ST_IDLE) && !blk_dvld;

  assign wdt_inc = wdt + 1'b1;
  assign wdt_hit = (TMO_CYC != 0) && (wdt_inc == WDT_W'(TMO_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      err      <= 1'b0;
      wdt      <= '0;
      blk_krdy <= 1'b0;
      blk_drdy <= 1'b0;
    end else begin
      blk_krdy <= start_k;
      blk_drdy <= start_d;
      if (ctrl_wr && wr_data[CTRL_CORE_RST]) begin
        state <= ST_IDLE;
        err   <= 1'b0;
        wdt   <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start_k) begin
              state <= ST_KEY_BUSY;
              wdt   <= '0;
            end else if (start_d) begin
              state <= ST_DATA_BUSY;
              wdt   <= '0;
            end
          end
          ST_KEY_BUSY: begin
            if (blk_kvld) begin
              state <= ST_IDLE;
            end else if (wdt_hit) begin
              state <= ST_IDLE;
              err   <= 1'b1;
              wdt   <= wdt_inc;
            end else begin
              wdt <= wdt_inc;
            end
          end
          ST_DATA_BUSY: begin
            if (blk_dvld) begin
              state <= ST_IDLE;
            end else if (wdt_hit) begin
              state <= ST_IDLE;
              err   <= 1'b1;
              wdt   <= wdt_inc;
            end else begin
              wdt <= wdt_inc;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_kin    <= '0;
      blk_din    <= '0;
      dout_reg   <= '0;
      blk_encdec <= 1'b0;
      core_rst   <= 1'b0;
      blk_en     <= 1'b0;
      blk_rstn   <= 1'b0;
      do_q       <= '0;
    end else begin
      blk_en <= 1'b1;
      if (ctrl_wr) begin
        core_rst <= wr_data[CTRL_CORE_RST];
        blk_rstn <= !wr_data[CTRL_CORE_RST];
      end else begin
        blk_rstn <= !core_rst;
      end
      if (wr_commit && (lbus.lbus_a == ADDR_MODE)) blk_encdec <= wr_data[0];
      for (int i = 0; i < KEY_WORDS; i++) begin
        if (wr_commit && (lbus.lbus_a == word_addr(ADDR_KEY, i)))
          blk_kin[127-16*i -: 16] <= wr_data;
      end
      for (int i = 0; i < DIN_WORDS; i++) begin
        if (wr_commit && (lbus.lbus_a == word_addr(ADDR_DIN, i)))
          blk_din[DIN_W-1-16*i -: 16] <= wr_data;
      end
      if (blk_dvld) dout_reg <= blk_dout;
      if (rd_sample) do_q <= rd_word;
    end
  end

  always_comb begin
    rd_word = '0;
    if (lbus.lbus_a == ADDR_CTRL)
      rd_word = {13'b0, err, (state == ST_KEY_BUSY), (state == ST_DATA_BUSY)};
    if (lbus.lbus_a == ADDR_VER)  rd_word = IP_VER;
    if (lbus.lbus_a == ADDR_MODE) rd_word = {15'b0, blk_encdec};
    for (int i = 0; i < KEY_WORDS; i++) begin
      if (lbus.lbus_a == word_addr(ADDR_KEY, i)) rd_word = blk_kin[127-16*i -: 16];
    end
    for (int i = 0; i < DIN_WORDS; i++) begin
      if (lbus.lbus_a == word_addr(ADDR_DIN, i)) rd_word = blk_din[DIN_W-1-16*i -: 16];
    end
    for (int i = 0; i < DOUT_WORDS; i++) begin
      if (lbus.lbus_a == word_addr(ADDR_DOUT, i)) rd_word = dout_reg[127-16*i -: 16];
    end
  end

  assign lbus.lbus_do = do_q;

endmodule
